// File: rtl/serial_byte_loader_if.sv
// Serial line in, parallel byte plus status pulses out, for the serial byte loader.
interface serial_byte_loader_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic [WIDTH-1:0] data_out;
    logic             load;
    logic             ferr;
    logic             busy;

    modport master (output sin, input data_out, load, ferr, busy);
    modport slave  (input sin, output data_out, load, ferr, busy);
endinterface

// File: rtl/serial_byte_loader.sv
// Start/stop-framed serial receiver feeding an 8-bit register: data_out drives DATA, load drives ENA.
module serial_byte_loader #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_byte_loader_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic             sync1_r, sync2_r;
    logic             sin_s;
    logic [CW-1:0]    cyc_r, cyc_s;
    logic [BW-1:0]    bit_r, bit_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] data_out_r, data_out_s;
    logic             load_r, load_s;
    logic             ferr_r, ferr_s;
    logic             busy_r, busy_s;

    assign sin_s = sync2_r;

    // State, counters, shift register, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            cyc_r      <= '0;
            bit_r      <= '0;
            shift_r    <= '0;
            data_out_r <= '0;
            load_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            sync1_r    <= bus.sin;
            sync2_r    <= sync1_r;
            cyc_r      <= cyc_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            data_out_r <= data_out_s;
            load_r     <= load_s;
            ferr_r     <= ferr_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic; every sample point is the last count of a half or full bit period.
    always_comb begin
        state_s    = state_r;
        cyc_s      = cyc_r + CW'(1);
        bit_s      = bit_r;
        shift_s    = shift_r;
        data_out_s = data_out_r;
        load_s     = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cyc_s = '0;
                if (!sin_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cyc_r == HALF_LAST) begin
                    cyc_s = '0;
                    bit_s = '0;
                    if (sin_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cyc_r == BIT_LAST) begin
                    cyc_s   = '0;
                    shift_s = {sin_s, shift_r[WIDTH-1:1]};
                    if (bit_r == DATA_LAST) begin
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (cyc_r == BIT_LAST) begin
                    cyc_s = '0;
                    if (sin_s) begin
                        data_out_s = shift_r;
                        load_s     = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_IDLE: begin
                // A line stuck low must return high before any new start bit counts.
                cyc_s = '0;
                if (sin_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cyc_s   = '0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    assign bus.data_out = data_out_r;
    assign bus.load     = load_r;
    assign bus.ferr     = ferr_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench for serial_byte_loader: frame table plus corner-case sequences, scoreboarded pulses.
module tb_serial_byte_loader;
    localparam int WIDTH = 8;
    localparam int CPB   = 4;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       is_load;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         pulse_count = 0;
    exp_t       sb[$];
    int         load_cycles[$];
    exp_t       mon_e;
    logic [7:0] reg_q;

    serial_byte_loader_if #(.WIDTH(WIDTH)) bus ();

    serial_byte_loader #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.sin = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic expect_pulse(input logic is_load, input logic [7:0] d);
        exp_t e;
        e.is_load = is_load;
        e.data    = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            tick(1);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Downstream register model and cycle counter.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst) reg_q <= 8'h00;
        else if (bus.load) reg_q <= bus.data_out;
    end

    // Scoreboard: every load/ferr cycle must match the next expected pulse.
    always @(negedge clk) begin
        if (bus.load || bus.ferr) begin
            pulse_count++;
            check("load_ferr_exclusive", {31'd0, bus.load & bus.ferr}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: load=%0b ferr=%0b data_out=%0h, expected no pulse (cycle %0d)",
                         bus.load, bus.ferr, bus.data_out, cycle);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind_load", {31'd0, bus.load}, {31'd0, mon_e.is_load});
                check("pulse_data_out", {24'd0, bus.data_out}, {24'd0, mon_e.data});
                if (bus.load) load_cycles.push_back(cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[5];
        int         busy_low;
        int         pc;
        logic [7:0] r0;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 8'hA5};
        vecs[2] = '{8'h5A, 1'b1, 8'h5A};
        vecs[3] = '{8'h01, 1'b0, 8'h5A};
        vecs[4] = '{8'hC3, 1'b1, 8'hC3};

        rst     = 1'b0;
        bus.sin = 1'b1;
        tick(3);
        check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("rst_load", {31'd0, bus.load}, 32'd0);
        check("rst_ferr", {31'd0, bus.ferr}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        tick(3);

        // Table of frames: good stop loads, bad stop flags FERR and keeps the old byte.
        for (int i = 0; i < 5; i++) begin
            expect_pulse(vecs[i].stop_bit, vecs[i].exp_data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            if (!vecs[i].stop_bit) begin
                busy_low = 0;
                for (int k = 0; k < 20; k++) begin
                    tick(1);
                    if (!bus.busy) busy_low++;
                end
                check("busy_while_line_low", busy_low, 0);
                bus.sin = 1'b1;
            end
            wait_drain("vec_drain");
            tick(6);
            check("vec_data_out", {24'd0, bus.data_out}, {24'd0, vecs[i].exp_data});
            check("vec_busy_idle", {31'd0, bus.busy}, 32'd0);
            check("vec_reg_q", {24'd0, reg_q}, {24'd0, vecs[i].exp_data});
        end

        // One-cycle glitch: START is entered, then rejected with no pulse.
        pc = pulse_count;
        bus.sin = 1'b0;
        tick(1);
        bus.sin = 1'b1;
        tick(2);
        check("glitch_start_busy", {31'd0, bus.busy}, 32'd1);
        tick(6);
        check("glitch_busy_idle", {31'd0, bus.busy}, 32'd0);
        check("glitch_no_pulse", pulse_count, pc);
        check("glitch_data_out", {24'd0, bus.data_out}, 32'hC3);

        // Reset during data bit 3 discards the partial frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        bus.sin = 1'b0;
        tick(3);
        check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        bus.sin = 1'b1;
        tick(1);
        check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("midrst_load", {31'd0, bus.load}, 32'd0);
        check("midrst_ferr", {31'd0, bus.ferr}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        tick(4);
        pc = pulse_count;
        expect_pulse(1'b1, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("after_rst_drain");
        tick(3);
        check("after_rst_data_out", {24'd0, bus.data_out}, 32'h81);
        check("after_rst_one_load", pulse_count - pc, 1);
        check("after_rst_reg_q", {24'd0, reg_q}, 32'h81);

        // Back-to-back frames with no idle gap: loads exactly 40 cycles apart.
        load_cycles.delete();
        expect_pulse(1'b1, 8'h00);
        expect_pulse(1'b1, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("b2b_drain");
        tick(2);
        check("b2b_load_count", load_cycles.size(), 2);
        if (load_cycles.size() == 2) check("b2b_spacing", load_cycles[1] - load_cycles[0], 40);
        check("b2b_data_out", {24'd0, bus.data_out}, 32'hFF);

        // Idle line for 100 cycles: register keeps its value.
        r0 = reg_q;
        pc = pulse_count;
        tick(100);
        check("idle_no_pulse", pulse_count, pc);
        check("idle_reg_q", {24'd0, reg_q}, {24'd0, r0});
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
